// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetch over AXI4-Lite into a DEPTH-entry queue; one read in flight, entry visible 2 cycles after AR.
// Fetch stalls when queue + in-flight would exceed DEPTH or after a faulting response; the IDU pops with out_valid/out_ready.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic        out_ebreak,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam int          PTR_W  = $clog2(DEPTH);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {ISSUE, WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]      r_req_pc;
  logic [31:0]      r_araddr, w_araddr_nxt;
  logic             r_arvalid, w_arvalid_nxt;
  logic             r_stale, w_stale_nxt;
  logic             r_halted, w_halted_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]      r_q_pc    [DEPTH];
  logic [31:0]      r_q_instr [DEPTH];
  logic             r_q_fault [DEPTH];

  logic        w_ar_hs, w_r_hs, w_push, w_pop, w_ar_stalled;
  logic [31:0] w_redirect_pc;
  logic        w_unused_pc_lsb;

  assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign w_ar_hs      = r_arvalid && arready;
  assign w_ar_stalled = r_arvalid && !arready;
  assign w_r_hs       = (r_state == WAIT) && rvalid;
  // Redirect beats both queue operations so the queue is empty the next cycle.
  assign w_push       = w_r_hs && !r_stale && !redirect_valid;
  assign w_pop        = out_valid && out_ready && !redirect_valid;

  assign arvalid    = r_arvalid;
  assign araddr     = r_araddr;
  assign rready     = (r_state == WAIT);
  assign out_valid  = (r_count != '0);
  assign out_pc     = r_q_pc[r_rd_ptr];
  assign out_instr  = r_q_instr[r_rd_ptr];
  assign out_fault  = r_q_fault[r_rd_ptr];
  assign out_ebreak = out_valid && (out_instr == EBREAK);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_stale_nxt    = r_stale;
    w_halted_nxt   = r_halted;
    unique case (r_state)
      ISSUE: begin
        if (w_ar_hs) begin
          w_state_nxt = WAIT;
          // A request already marked stale was for the old stream; fetch_pc already holds the target.
          if (!r_stale) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      WAIT: begin
        if (w_r_hs) begin
          w_state_nxt = ISSUE;
          w_stale_nxt = 1'b0;
          if (w_push && (rresp != 2'b00)) w_halted_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ISSUE;
    endcase
    if (redirect_valid) begin
      w_fetch_pc_nxt = w_redirect_pc;
      w_halted_nxt   = 1'b0;
      if (((r_state == WAIT) && !w_r_hs) || r_arvalid) w_stale_nxt = 1'b1;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Registered AR: the space check looks at next-cycle occupancy so a new AR can follow the R beat directly.
  always_comb begin
    w_arvalid_nxt = w_ar_stalled ||
                    ((w_state_nxt == ISSUE) && !w_halted_nxt && (w_count_nxt < CNT_W'(DEPTH)));
    w_araddr_nxt  = w_ar_stalled ? r_araddr : w_fetch_pc_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ISSUE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_araddr   <= RESET_PC;
      r_arvalid  <= 1'b0;
      r_stale    <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_araddr   <= w_araddr_nxt;
      r_arvalid  <= w_arvalid_nxt;
      r_stale    <= w_stale_nxt;
      r_halted   <= w_halted_nxt;
      r_count    <= w_count_nxt;
      if (w_ar_hs) r_req_pc <= r_araddr;
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_req_pc;
      r_q_instr[r_wr_ptr] <= rdata;
      r_q_fault[r_wr_ptr] <= (rresp != 2'b00);
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: AXI4-Lite memory model plus a stream-level model of the instruction sequence the IDU should see.
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, out_fault, out_ebreak;
  logic [31:0] out_pc, out_instr;
  logic [31:0] araddr, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_fault(out_fault), .out_ebreak(out_ebreak),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int total = 0;
  int bad   = 0;

  // memory / stimulus knobs
  int          lat_min, lat_max, ready_mode, stall_next, stall_left;
  bit          rnd_ar, chk_b2b, redir_req;
  logic [31:0] redir_target, err_addr;
  // outstanding read in the memory model
  bit          s_pend;
  logic [31:0] s_addr;
  int          s_tag, s_delay;
  // AR currently presented but not yet accepted
  bit          ar_wait;
  logic [31:0] ar_addr_prev;
  int          ar_tag;
  // stream model: epoch bumps on every redirect/reset; responses from older epochs are discarded
  int          epoch, mq_cnt;
  bit          m_halted;
  logic [31:0] exp_issue, exp_deliver;
  int          n_ar, n_pop, n_ebreak, cyc, last_ar_cyc;
  logic [31:0] ar_log [$];
  logic [31:0] pop_pc [$];
  bit          pop_fault [$];

  typedef struct {
    logic [31:0] target;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } redir_vec_t;
  redir_vec_t vecs [4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[5:0] == 6'h24) return EBREAK;
    return {a[15:0] ^ a[31:16], 16'hC0DE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: check outputs, drive inputs, then account for the handshakes of the coming rising edge.
  task automatic step();
    bit ar_hs, r_hs, pop;
    if (ar_wait) begin
      chkb("ar_hold_valid", arvalid, 1'b1);
      chk("ar_hold_addr", araddr, ar_addr_prev);
    end
    if (arvalid && !ar_wait) begin
      chkb("ar_single_outstanding", s_pend, 1'b0);
      chkb("ar_while_halted", m_halted, 1'b0);
      chkb("ar_space", mq_cnt < DEPTH, 1'b1);
      ar_tag = epoch;
      if (stall_next > 0) begin
        stall_left = stall_next;
        stall_next = 0;
      end
    end
    chkb("out_valid", out_valid, mq_cnt != 0);
    if (out_valid && mq_cnt != 0) begin
      chk("out_pc", out_pc, exp_deliver);
      chk("out_instr", out_instr, mem_word(exp_deliver));
      chkb("out_fault", out_fault, exp_deliver == err_addr);
      chkb("out_ebreak", out_ebreak, mem_word(exp_deliver) == EBREAK);
    end else if (!out_valid) begin
      chkb("out_ebreak_idle", out_ebreak, 1'b0);
    end

    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    redir_req      = 1'b0;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (arvalid && stall_left > 0) begin
      arready = 1'b0;
      stall_left--;
    end else begin
      arready = rnd_ar ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (s_pend && s_delay == 0) begin
      rvalid = 1'b1;
      rdata  = mem_word(s_addr);
      rresp  = (s_addr == err_addr) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'b00;
      if (s_pend) s_delay--;
    end

    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    pop   = out_valid && out_ready && !redirect_valid;
    if (redirect_valid) begin
      epoch++;
      mq_cnt      = 0;
      exp_issue   = redirect_pc & 32'hFFFF_FFFC;
      exp_deliver = exp_issue;
      m_halted    = 1'b0;
    end
    if (pop) begin
      pop_pc.push_back(out_pc);
      pop_fault.push_back(out_fault);
      if (out_ebreak) n_ebreak++;
      n_pop++;
      if (mq_cnt > 0) mq_cnt--;
      exp_deliver += 32'd4;
    end
    if (r_hs) begin
      if (s_tag == epoch) begin
        chk("resp_addr_seq", s_addr, exp_issue);
        exp_issue += 32'd4;
        chkb("push_not_full", mq_cnt < DEPTH, 1'b1);
        mq_cnt++;
        if (s_addr == err_addr) m_halted = 1'b1;
      end
      s_pend = 1'b0;
    end
    if (ar_hs) begin
      s_pend  = 1'b1;
      s_addr  = araddr;
      s_tag   = ar_tag;
      s_delay = int'($urandom_range(lat_min, lat_max));
      ar_log.push_back(araddr);
      if (chk_b2b && n_ar > 0) chk("b2b_ar_spacing", 32'(cyc - last_ar_cyc), 32'd2);
      last_ar_cyc = cyc;
      n_ar++;
      ar_wait = 1'b0;
    end else if (arvalid) begin
      ar_wait      = 1'b1;
      ar_addr_prev = araddr;
    end else begin
      ar_wait = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Entered at a falling edge; rst rises half a cycle before the next rising edge.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    arready        = 1'b0;
    rvalid         = 1'b0;
    out_ready      = 1'b0;
    #1;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_arvalid", arvalid, 1'b0);
    chkb("rst_rready", rready, 1'b0);
    chkb("rst_out_ebreak", out_ebreak, 1'b0);
    chk("rst_araddr", araddr, RESET_PC);
    epoch++;
    mq_cnt      = 0;
    m_halted    = 1'b0;
    exp_issue   = RESET_PC;
    exp_deliver = RESET_PC;
    s_pend      = 1'b0;
    ar_wait     = 1'b0;
    stall_left  = 0;
    stall_next  = 0;
    redir_req   = 1'b0;
    n_ar        = 0;
    n_pop       = 0;
    n_ebreak    = 0;
    ar_log.delete();
    pop_pc.delete();
    pop_fault.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    logic [31:0] old_addr;
    vecs[0] = '{target: 32'h8000_1002, pc0: 32'h8000_1000, pc1: 32'h8000_1004};
    vecs[1] = '{target: 32'h1234_5677, pc0: 32'h1234_5674, pc1: 32'h1234_5678};
    vecs[2] = '{target: 32'hFFFF_FFFE, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000};
    vecs[3] = '{target: 32'h0000_0001, pc0: 32'h0000_0000, pc1: 32'h0000_0004};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    lat_min = 0; lat_max = 0; ready_mode = 0; rnd_ar = 1'b0; chk_b2b = 1'b0;
    err_addr = 32'h0000_0001; redir_target = '0; epoch = 0; cyc = 0; last_ar_cyc = 0;
    s_addr = '0; s_tag = 0; s_delay = 0; ar_tag = 0; ar_addr_prev = '0;
    @(negedge clk);

    // sequential fill with a stalled IDU
    do_reset();
    chk_b2b = 1'b1;
    repeat (20) step();
    chk_b2b = 1'b0;
    chk("fill_ar_count", 32'(n_ar), 32'd4);
    for (int i = 0; i < 4 && i < ar_log.size(); i++) chk("fill_ar_addr", ar_log[i], RESET_PC + 32'(4 * i));
    chkb("fill_arvalid_idle", arvalid, 1'b0);
    chk("fill_head_pc", out_pc, RESET_PC);
    chk("fill_head_instr", out_instr, mem_word(RESET_PC));

    // streaming 64 instructions
    do_reset();
    ready_mode = 1; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 2000 && n_pop < 64; k++) step();
    chk("stream_pops", 32'(n_pop), 32'd64);
    for (int i = 0; i < 64 && i < pop_pc.size(); i++) chk("stream_pc_seq", pop_pc[i], RESET_PC + 32'(4 * i));
    chk("stream_ebreaks", 32'(n_ebreak), 32'd4);

    // redirect while a read is in flight
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 50 && !rready; k++) step();
    chkb("redir_wait_reached", rready, 1'b1);
    redir_req = 1'b1; redir_target = 32'h8000_1002;
    ar_log.delete(); p0 = pop_pc.size();
    step();
    chkb("redir_queue_empty", out_valid, 1'b0);
    for (int k = 0; k < 100 && pop_pc.size() <= p0; k++) step();
    chk("redir_first_ar", (ar_log.size() > 0) ? ar_log[0] : 32'hDEAD_BEEF, 32'h8000_1000);
    chk("redir_first_pc", (pop_pc.size() > p0) ? pop_pc[p0] : 32'hDEAD_BEEF, 32'h8000_1000);

    // redirect while arvalid is held off by the slave
    lat_min = 1; lat_max = 1; stall_next = 5;
    for (int k = 0; k < 50 && !ar_wait; k++) step();
    chkb("stall_reached", ar_wait, 1'b1);
    old_addr = ar_addr_prev;
    redir_req = 1'b1; redir_target = 32'h8000_2000;
    ar_log.delete(); p0 = pop_pc.size();
    step();
    for (int k = 0; k < 100 && (ar_log.size() < 2 || pop_pc.size() <= p0); k++) step();
    chk("stall_stale_ar", (ar_log.size() > 0) ? ar_log[0] : 32'hDEAD_BEEF, old_addr);
    chk("stall_next_ar", (ar_log.size() > 1) ? ar_log[1] : 32'hDEAD_BEEF, 32'h8000_2000);
    chk("stall_first_pc", (pop_pc.size() > p0) ? pop_pc[p0] : 32'hDEAD_BEEF, 32'h8000_2000);

    // redirect target table: low bits dropped, 32-bit wrap
    lat_min = 0; lat_max = 2;
    for (int v = 0; v < 4; v++) begin
      redir_req = 1'b1; redir_target = vecs[v].target;
      p0 = pop_pc.size();
      for (int k = 0; k < 200 && pop_pc.size() < p0 + 2; k++) step();
      chk("vec_pc0", (pop_pc.size() > p0) ? pop_pc[p0] : 32'hDEAD_BEEF, vecs[v].pc0);
      chk("vec_pc1", (pop_pc.size() > p0 + 1) ? pop_pc[p0 + 1] : 32'hDEAD_BEEF, vecs[v].pc1);
    end

    // bus error at the third fetch
    err_addr = 32'h8000_0008;
    do_reset();
    ready_mode = 1; lat_min = 0; lat_max = 0;
    repeat (60) step();
    chk("err_pop_count", 32'(pop_pc.size()), 32'd3);
    if (pop_pc.size() >= 3) begin
      chk("err_pc0", pop_pc[0], 32'h8000_0000); chkb("err_fault0", pop_fault[0], 1'b0);
      chk("err_pc1", pop_pc[1], 32'h8000_0004); chkb("err_fault1", pop_fault[1], 1'b0);
      chk("err_pc2", pop_pc[2], 32'h8000_0008); chkb("err_fault2", pop_fault[2], 1'b1);
    end
    chk("err_ar_count", 32'(n_ar), 32'd3);
    redir_req = 1'b1; redir_target = 32'h8000_0200;
    for (int k = 0; k < 100 && pop_pc.size() < 5; k++) step();
    chk("err_resume_pc", (pop_pc.size() > 3) ? pop_pc[3] : 32'hDEAD_BEEF, 32'h8000_0200);
    chkb("err_resume_fault", (pop_fault.size() > 3) ? pop_fault[3] : 1'b1, 1'b0);

    // asynchronous reset while waiting for read data
    lat_min = 4; lat_max = 4;
    for (int k = 0; k < 50 && !rready; k++) step();
    chkb("arst_wait_reached", rready, 1'b1);
    do_reset();
    lat_min = 0; lat_max = 1;
    for (int k = 0; k < 50 && ar_log.size() == 0; k++) step();
    chk("arst_first_ar", (ar_log.size() > 0) ? ar_log[0] : 32'hDEAD_BEEF, RESET_PC);

    // randomized traffic with redirects, stalls and an error location
    err_addr = 32'h8000_00A0;
    rnd_ar = 1'b1; ready_mode = 2; lat_min = 0; lat_max = 3;
    p0 = n_pop;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        redir_req    = 1'b1;
        redir_target = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                     : (32'h8000_0000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 29) == 0) stall_next = int'($urandom_range(1, 4));
      step();
    end
    chkb("rand_progress", (n_pop - p0) > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction fetch unit with a DEPTH-entry prefetch queue between the AXI4-Lite instruction read port and the IDU.
- Keeps issuing sequential fetches while the queue has room, so the IDU does not wait a full bus round trip per instruction.
- Supports redirect (branch/trap) with queue flush and discard of stale in-flight responses.
- Reports bus errors as a per-instruction fault flag instead of silently latching data.

Parameters:
- RESET_PC, 32'h80000000, fetch address after reset.
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits[1:0] forced to 0
- out_valid  out  1  queue head valid to IDU
- out_ready  in  1  IDU accepts head
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction word
- out_fault  out  1  head fetch returned rresp != 2'b00
- out_ebreak  out  1  out_valid && out_instr == 32'h00100073
- araddr  out  32  AXI read address
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI data valid
- rready  out  1  AXI data ready

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; queue empty; out_valid = 0.
  - arvalid = 0, rready = 0, araddr = RESET_PC.
  - state = ISSUE; stale = 0; halted = 0.
- At most one outstanding read. Fetch is allowed when count + pending < DEPTH, where pending = 1 while in WAIT.
- FSM:
  - ISSUE:
    - If !halted and there is space, drive arvalid = 1 with araddr = fetch_pc.
    - On arvalid && arready: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap), arvalid <= 0 → WAIT.
  - WAIT:
    - rready = 1.
    - On rvalid && rready, if !stale, push {req_pc, rdata, rresp != 0}. stale <= 0 → ISSUE.
- Once asserted, arvalid and araddr stay stable until arready (AXI rule), including across a redirect.
- Earliest back-to-back timing: AR handshake in cycle N, R handshake in N+1, entry visible on out_valid in N+2, next AR issued in N+2.
- Queue:
  - Head is registered and shown on out_pc/out_instr/out_fault.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push on a full queue cannot occur; the space check makes it impossible, and the bench asserts it never happens.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_valid = 1):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; queue cleared (count = 0, pointers reset); halted <= 0.
  - If in WAIT, or if an AR handshake completes in the same cycle, stale <= 1 and that response is accepted (rready) then dropped.
  - If arvalid is high and not yet accepted, the request completes at the old address and is marked stale. The next AR then uses the new fetch_pc.
  - Redirect wins over a same-cycle pop or push: the queue is empty next cycle.
  - Redirect in the same cycle as a stale response clears the old stale request; no new stale request is created.
- Fault:
  - A non-stale response with rresp != 0 is pushed with fault = 1, and halted <= 1.
  - No further AR is issued until redirect.
  - Entries already queued still drain normally.
- out_ebreak is combinational from the head. The simulation environment uses it to stop; this block contains no DPI call.
- rst asserted mid-transaction returns everything to reset values immediately. Any bus response already in flight must be cleared by the interconnect reset.

Test Plan:
- Sequential fill:
  - Stimulus: zero-wait memory, out_ready = 0, DEPTH = 4.
  - Required: exactly 4 ARs at 0x80000000..0x8000000C, then arvalid stays 0.
  - Required: out_pc = 0x80000000 with its word.
- Streaming:
  - Stimulus: out_ready = 1, 1-cycle memory.
  - Required: PCs delivered strictly +4, no duplicates or gaps over 64 instructions.
  - Required: out_ebreak = 1 exactly on word 0x00100073.
- Redirect with in-flight read:
  - Stimulus: redirect to 0x80001002 while in WAIT.
  - Required: old response dropped; queue empty next cycle.
  - Required: next AR address = 0x80001000; first out_pc = 0x80001000.
- Redirect while arvalid is stalled:
  - Stimulus: arready held 0 for 5 cycles, redirect in cycle 2.
  - Required: araddr unchanged until accepted; that response is discarded.
  - Required: following AR is at the redirect target.
- Bus error:
  - Stimulus: rresp = 2'b10 at 0x80000008.
  - Required: entries for 0x80000000 and 0x80000004 delivered, then out_fault = 1 at out_pc = 0x80000008.
  - Required: no further AR until redirect, then fetch resumes.
- Async reset mid-WAIT:
  - Stimulus: assert rst.
  - Required: out_valid, arvalid and rready all 0 before the next clk edge.
  - Required: first AR after release is at 0x80000000.
